// File: rtl/tetris_title_renderer.sv
// ---------------------------------------------------------------------------
// tetris_title_renderer
//
// Pixel-pipeline stage that draws the animated "TETRIS" title banner.
// Stage 1 registers the banner-relative row/column/letter of the current
// raster position; the font and color ROMs are addressed combinationally
// from those registers. Stage 2 registers the lit flag and pixel colour.
// A small FSM reveals the letters one at a time, then rotates the per-letter
// colours, advancing only on frame boundaries.
//
// Ports:
//   Clk          in   pixel clock
//   Reset        in   synchronous, active-high reset
//   DrawX/DrawY  in   current raster column/row (10 bits each)
//   frame_start  in   one-cycle pulse at the start of each frame
//   show         in   one-cycle pulse: begin the letter reveal
//   hide         in   one-cycle pulse: blank the banner, return to HIDDEN
//   font_addr    out  font ROM row address (0..9)
//   font_data    in   font ROM row, bit 59 is the leftmost pixel
//   color_addr   out  color ROM address (0..5)
//   color_data   in   color ROM RGB
//   title_on     out  registered: pixel is a lit banner pixel
//   title_rgb    out  registered: pixel colour, 12'h000 when title_on=0
//   state_o      out  FSM state (00 HIDDEN, 01 REVEAL, 10 CYCLE)
// ---------------------------------------------------------------------------
module tetris_title_renderer #(
    parameter int TITLE_X       = 400,
    parameter int TITLE_Y       = 40,
    parameter int SCALE         = 3,
    parameter int REVEAL_FRAMES = 8,
    parameter int CYCLE_FRAMES  = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        frame_start,
    input  logic        show,
    input  logic        hide,
    output logic [3:0]  font_addr,
    input  logic [59:0] font_data,
    output logic [2:0]  color_addr,
    input  logic [11:0] color_data,
    output logic        title_on,
    output logic [11:0] title_rgb,
    output logic [1:0]  state_o
);

    // Banner bounds widened to 11 bits so TITLE_X + width cannot overflow.
    localparam logic [10:0] X_LO = 11'(TITLE_X);
    localparam logic [10:0] X_HI = 11'(TITLE_X + 60 * SCALE);
    localparam logic [10:0] Y_LO = 11'(TITLE_Y);
    localparam logic [10:0] Y_HI = 11'(TITLE_Y + 10 * SCALE);
    localparam logic [10:0] SCALE_W = 11'(SCALE);

    localparam logic [15:0] REVEAL_LAST = 16'(REVEAL_FRAMES - 1);
    localparam logic [15:0] CYCLE_LAST  = 16'(CYCLE_FRAMES - 1);

    typedef enum logic [1:0] {
        HIDDEN = 2'b00,
        REVEAL = 2'b01,
        CYCLE  = 2'b10
    } state_t;

    // Reduce a sum of two values in 0..5 (so at most 10) modulo 6.
    function automatic logic [2:0] wrap6(input logic [3:0] v);
        logic [2:0] r;
        if (v >= 4'd6) begin
            r = 3'(v - 4'd6);
        end else begin
            r = v[2:0];
        end
        return r;
    endfunction

    // Stage-1 combinational signals
    logic [10:0] x_s, y_s, dx_s, dy_s;
    logic        in_box_s;
    logic [3:0]  row_s;
    logic [5:0]  col_s;
    logic [2:0]  letter_s;

    // Stage-1 registers
    logic        in_box_r;
    logic [3:0]  row_r;
    logic [5:0]  col_r;
    logic [2:0]  letter_r;

    // Stage-2 combinational signal
    logic        lit_s;

    // FSM state and counters
    state_t      state_r, state_nx;
    logic [2:0]  reveal_r, reveal_nx;
    logic [15:0] frame_r, frame_nx;
    logic [2:0]  offset_r, offset_nx;

    // Banner-relative coordinates; out-of-box values forced to zero so the
    // ROM addresses stay inside their legal ranges.
    always_comb begin
        x_s      = {1'b0, DrawX};
        y_s      = {1'b0, DrawY};
        dx_s     = x_s - X_LO;
        dy_s     = y_s - Y_LO;
        in_box_s = (x_s >= X_LO) && (x_s < X_HI) && (y_s >= Y_LO) && (y_s < Y_HI);
        if (in_box_s) begin
            col_s    = 6'(dx_s / SCALE_W);
            row_s    = 4'(dy_s / SCALE_W);
            letter_s = 3'(col_s / 6'd10);
        end else begin
            col_s    = 6'd0;
            row_s    = 4'd0;
            letter_s = 3'd0;
        end
    end

    // Stage-1 pipeline registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            in_box_r <= 1'b0;
            row_r    <= 4'd0;
            col_r    <= 6'd0;
            letter_r <= 3'd0;
        end else begin
            in_box_r <= in_box_s;
            row_r    <= row_s;
            col_r    <= col_s;
            letter_r <= letter_s;
        end
    end

    // ROM addresses from stage-1 registers; held at zero while in reset.
    always_comb begin
        if (Reset) begin
            font_addr  = 4'd0;
            color_addr = 3'd0;
        end else begin
            font_addr  = row_r;
            color_addr = wrap6({1'b0, letter_r} + {1'b0, offset_r});
        end
    end

    // A pixel is lit when inside the banner, its font bit is set and its
    // letter has already been revealed.
    always_comb begin
        lit_s = in_box_r & font_data[6'd59 - col_r] & (letter_r < reveal_r);
    end

    // Stage-2 output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            title_on  <= 1'b0;
            title_rgb <= 12'h000;
        end else begin
            title_on  <= lit_s;
            title_rgb <= lit_s ? color_data : 12'h000;
        end
    end

    // FSM state and counter registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r  <= HIDDEN;
            reveal_r <= 3'd0;
            frame_r  <= 16'd0;
            offset_r <= 3'd0;
        end else begin
            state_r  <= state_nx;
            reveal_r <= reveal_nx;
            frame_r  <= frame_nx;
            offset_r <= offset_nx;
        end
    end

    // Next-state logic. hide overrides everything, which also makes it win
    // over a simultaneous show. A frame_start coinciding with show is not
    // counted because the HIDDEN branch never looks at frame_start.
    always_comb begin
        state_nx  = state_r;
        reveal_nx = reveal_r;
        frame_nx  = frame_r;
        offset_nx = offset_r;
        if (hide) begin
            state_nx  = HIDDEN;
            reveal_nx = 3'd0;
            frame_nx  = 16'd0;
            offset_nx = 3'd0;
        end else begin
            case (state_r)
                HIDDEN: begin
                    if (show) begin
                        state_nx  = REVEAL;
                        reveal_nx = 3'd1;
                        frame_nx  = 16'd0;
                    end else begin
                        reveal_nx = 3'd0;
                        frame_nx  = 16'd0;
                    end
                end
                REVEAL: begin
                    if (frame_start) begin
                        if (frame_r == REVEAL_LAST) begin
                            frame_nx  = 16'd0;
                            reveal_nx = reveal_r + 3'd1;
                            if (reveal_r == 3'd5) begin
                                state_nx = CYCLE;
                            end else begin
                                state_nx = REVEAL;
                            end
                        end else begin
                            frame_nx = frame_r + 16'd1;
                        end
                    end else begin
                        frame_nx = frame_r;
                    end
                end
                CYCLE: begin
                    reveal_nx = 3'd6;
                    if (frame_start) begin
                        if (frame_r == CYCLE_LAST) begin
                            frame_nx  = 16'd0;
                            offset_nx = (offset_r == 3'd5) ? 3'd0 : offset_r + 3'd1;
                        end else begin
                            frame_nx = frame_r + 16'd1;
                        end
                    end else begin
                        frame_nx = frame_r;
                    end
                end
                default: begin
                    state_nx  = HIDDEN;
                    reveal_nx = 3'd0;
                    frame_nx  = 16'd0;
                    offset_nx = 3'd0;
                end
            endcase
        end
    end

    assign state_o = state_r;

endmodule
